// File: rtl/ecc_pkg.sv
// Shared definitions for the elliptic-curve point checker: FSM encoding,
// default operand width and the modular-add helper.
package ecc_pkg;

   localparam int ECC_INT_SIZE = 64;
   localparam int ECC_MAX_W    = 256;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LOAD    = 4'd1,
      ST_RANGE   = 4'd2,
      ST_MUL_XX  = 4'd3,
      ST_MUL_XXX = 4'd4,
      ST_MUL_AX  = 4'd5,
      ST_MUL_YY  = 4'd6,
      ST_ADD_AX  = 4'd7,
      ST_ADD_B   = 4'd8,
      ST_CMP     = 4'd9,
      ST_DONE    = 4'd10
   } ecc_state_e;

   // Operands are zero-extended to ECC_MAX_W; with x, y < p one subtract suffices.
   function automatic logic [ECC_MAX_W-1:0] add_mod(input logic [ECC_MAX_W-1:0] x,
                                                    input logic [ECC_MAX_W-1:0] y,
                                                    input logic [ECC_MAX_W-1:0] p);
      logic [ECC_MAX_W:0] sum_s;
      sum_s = {1'b0, x} + {1'b0, y};
      if (sum_s >= {1'b0, p}) begin
         sum_s = sum_s - {1'b0, p};
      end else begin
         sum_s = sum_s;
      end
      return sum_s[ECC_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: MSB-first acc = 2*acc + a_bit*b mod prime.
// prime must stay stable from start until done.
module mod_mul_serial
   import ecc_pkg::*;
#(
   parameter int integer_size = ECC_INT_SIZE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [integer_size-1:0] a,
   input  logic [integer_size-1:0] b,
   input  logic [integer_size-1:0] prime,
   output logic [integer_size-1:0] product,
   output logic                    done
);

   localparam int CW = $clog2(integer_size + 1);
   localparam int AW = integer_size + 2;

   logic [AW-1:0]           acc_r;
   logic [integer_size-1:0] a_r;
   logic [integer_size-1:0] b_r;
   logic [CW-1:0]           cnt_r;
   logic                    run_r;
   logic                    done_r;
   logic [AW-1:0]           p_ext_s;
   logic [AW-1:0]           dbl_s;
   logic [AW-1:0]           sub1_s;
   logic [AW-1:0]           sub2_s;

   // One iteration: 2*acc + bit*b stays below 3*prime, so two subtracts reduce it.
   always_comb begin
      p_ext_s = {2'b00, prime};
      dbl_s   = (acc_r << 1) + (a_r[integer_size-1] ? {2'b00, b_r} : {AW{1'b0}});
      sub1_s  = (dbl_s >= p_ext_s) ? (dbl_s - p_ext_s) : dbl_s;
      sub2_s  = (sub1_s >= p_ext_s) ? (sub1_s - p_ext_s) : sub1_s;
   end

   // Operand capture, iteration counter and completion pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r  <= {AW{1'b0}};
         a_r    <= {integer_size{1'b0}};
         b_r    <= {integer_size{1'b0}};
         cnt_r  <= {CW{1'b0}};
         run_r  <= 1'b0;
         done_r <= 1'b0;
      end else if (start) begin
         acc_r  <= {AW{1'b0}};
         a_r    <= a;
         b_r    <= b;
         cnt_r  <= CW'(integer_size);
         run_r  <= 1'b1;
         done_r <= 1'b0;
      end else if (run_r) begin
         acc_r  <= sub2_s;
         a_r    <= a_r << 1;
         cnt_r  <= cnt_r - CW'(1);
         run_r  <= (cnt_r != CW'(1));
         done_r <= (cnt_r == CW'(1));
      end else begin
         done_r <= 1'b0;
      end
   end

   assign product = acc_r[integer_size-1:0];
   assign done    = done_r;

endmodule

// File: rtl/ecc_point_check.sv
// Affine point validator for y^2 = x^3 + A*x + B mod prime using one shared serial multiplier.
// Define ECC_PTCHK_NEG_EN to add the negPy output (prime - Py, or 0).
module ecc_point_check
   import ecc_pkg::*;
#(
   parameter int integer_size = ECC_INT_SIZE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    go,
   input  logic [integer_size-1:0] prime,
   input  logic [integer_size-1:0] A,
   input  logic [integer_size-1:0] B,
   input  logic [integer_size-1:0] Px,
   input  logic [integer_size-1:0] Py,
   input  logic                    infiniteP,
`ifdef ECC_PTCHK_NEG_EN
   output logic [integer_size-1:0] negPy,
`endif
   output logic                    busy,
   output logic                    done,
   output logic                    on_curve,
   output logic                    range_err
);

   localparam int N = integer_size;

   ecc_state_e  state_r, next_s;
   logic [N-1:0] p_r, a_r, b_r, x_r, y_r;
   logic [N-1:0] t1_r, t2_r, t3_r;
   logic         inf_r;
   logic         mul_run_r;
   logic         busy_r, done_r, on_curve_r, range_err_r;
   logic         start_s, mul_done_s, bad_s;
   logic [N-1:0] mul_a_s, mul_b_s, prod_s;

   assign bad_s = (p_r < N'(3)) || !p_r[0] || (x_r >= p_r) || (y_r >= p_r) ||
                  (a_r >= p_r) || (b_r >= p_r);

   mod_mul_serial #(.integer_size(N)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (start_s),
      .a       (mul_a_s),
      .b       (mul_b_s),
      .prime   (p_r),
      .product (prod_s),
      .done    (mul_done_s)
   );

   // Next-state logic and multiplier operand selection; start fires on the first MUL cycle.
   always_comb begin
      next_s  = state_r;
      start_s = 1'b0;
      mul_a_s = x_r;
      mul_b_s = x_r;
      case (state_r)
         ST_IDLE:    next_s = go ? ST_LOAD : ST_IDLE;
         ST_LOAD:    next_s = ST_RANGE;
         ST_RANGE: begin
            if (inf_r || bad_s) begin
               next_s = ST_DONE;
            end else begin
               next_s = ST_MUL_XX;
            end
         end
         ST_MUL_XX: begin
            start_s = !mul_run_r;
            next_s  = mul_done_s ? ST_MUL_XXX : ST_MUL_XX;
         end
         ST_MUL_XXX: begin
            mul_a_s = t1_r;
            start_s = !mul_run_r;
            next_s  = mul_done_s ? ST_MUL_AX : ST_MUL_XXX;
         end
         ST_MUL_AX: begin
            mul_a_s = a_r;
            start_s = !mul_run_r;
            next_s  = mul_done_s ? ST_MUL_YY : ST_MUL_AX;
         end
         ST_MUL_YY: begin
            mul_a_s = y_r;
            mul_b_s = y_r;
            start_s = !mul_run_r;
            next_s  = mul_done_s ? ST_ADD_AX : ST_MUL_YY;
         end
         ST_ADD_AX:  next_s = ST_ADD_B;
         ST_ADD_B:   next_s = ST_CMP;
         ST_CMP:     next_s = ST_DONE;
         ST_DONE:    next_s = go ? ST_DONE : ST_IDLE;
         default:    next_s = ST_IDLE;
      endcase
   end

   // State register and registered status outputs, derived from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         mul_run_r   <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         on_curve_r  <= 1'b0;
         range_err_r <= 1'b0;
      end else begin
         state_r   <= next_s;
         busy_r    <= (next_s != ST_IDLE) && (next_s != ST_DONE);
         done_r    <= (next_s == ST_DONE);
         if (start_s) begin
            mul_run_r <= 1'b1;
         end else if (mul_done_s) begin
            mul_run_r <= 1'b0;
         end else begin
            mul_run_r <= mul_run_r;
         end
         if (next_s == ST_IDLE) begin
            on_curve_r  <= 1'b0;
            range_err_r <= 1'b0;
         end else if (state_r == ST_RANGE && inf_r) begin
            on_curve_r  <= 1'b1;
            range_err_r <= 1'b0;
         end else if (state_r == ST_RANGE && bad_s) begin
            on_curve_r  <= 1'b0;
            range_err_r <= 1'b1;
         end else if (state_r == ST_CMP) begin
            on_curve_r  <= (t1_r == t3_r);
            range_err_r <= 1'b0;
         end else begin
            on_curve_r  <= on_curve_r;
            range_err_r <= range_err_r;
         end
      end
   end

   // Operand capture and intermediate results; t1 accumulates x^3 + A*x + B.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_r   <= {N{1'b0}};
         a_r   <= {N{1'b0}};
         b_r   <= {N{1'b0}};
         x_r   <= {N{1'b0}};
         y_r   <= {N{1'b0}};
         inf_r <= 1'b0;
         t1_r  <= {N{1'b0}};
         t2_r  <= {N{1'b0}};
         t3_r  <= {N{1'b0}};
      end else begin
         case (state_r)
            ST_LOAD: begin
               p_r   <= prime;
               a_r   <= A;
               b_r   <= B;
               x_r   <= Px;
               y_r   <= Py;
               inf_r <= infiniteP;
            end
            ST_MUL_XX, ST_MUL_XXX: if (mul_done_s) t1_r <= prod_s;
            ST_MUL_AX:  if (mul_done_s) t2_r <= prod_s;
            ST_MUL_YY:  if (mul_done_s) t3_r <= prod_s;
            ST_ADD_AX:  t1_r <= N'(add_mod(ECC_MAX_W'(t1_r), ECC_MAX_W'(t2_r), ECC_MAX_W'(p_r)));
            ST_ADD_B:   t1_r <= N'(add_mod(ECC_MAX_W'(t1_r), ECC_MAX_W'(b_r), ECC_MAX_W'(p_r)));
            default:    t1_r <= t1_r;
         endcase
      end
   end

`ifdef ECC_PTCHK_NEG_EN
   logic [N-1:0] negpy_r;

   // Negated y captured on entry to DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         negpy_r <= {N{1'b0}};
      end else if (next_s == ST_DONE && state_r != ST_DONE) begin
         negpy_r <= (inf_r || y_r == {N{1'b0}}) ? {N{1'b0}} : (p_r - y_r);
      end else begin
         negpy_r <= negpy_r;
      end
   end

   assign negPy = negpy_r;
`endif

   assign busy      = busy_r;
   assign done      = done_r;
   assign on_curve  = on_curve_r;
   assign range_err = range_err_r;

endmodule

// File: tb/tb_ecc_point_check.sv
// Directed and randomized checks of ecc_point_check at widths 8 and 64 against an arithmetic model.
module tb_ecc_point_check;

   localparam logic [63:0] PRIME64 = 64'hFFFF_FFFF_FFFF_FFC5;

   logic clk = 1'b0;
   logic rst;
   logic go8, inf8, busy8, done8, on8, err8;
   logic [7:0] p8, a8, b8, x8, y8;
   logic go64, inf64, busy64, done64, on64, err64;
   logic [63:0] p64, a64, b64, x64, y64;
`ifdef ECC_PTCHK_NEG_EN
   logic [7:0]  neg8;
   logic [63:0] neg64;
`endif
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ecc_point_check #(.integer_size(8)) dut8 (
      .clk(clk), .rst(rst), .go(go8), .prime(p8), .A(a8), .B(b8), .Px(x8), .Py(y8),
      .infiniteP(inf8),
`ifdef ECC_PTCHK_NEG_EN
      .negPy(neg8),
`endif
      .busy(busy8), .done(done8), .on_curve(on8), .range_err(err8));

   ecc_point_check #(.integer_size(64)) dut64 (
      .clk(clk), .rst(rst), .go(go64), .prime(p64), .A(a64), .B(b64), .Px(x64), .Py(y64),
      .infiniteP(inf64),
`ifdef ECC_PTCHK_NEG_EN
      .negPy(neg64),
`endif
      .busy(busy64), .done(done64), .on_curve(on64), .range_err(err64));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y,
                                          input logic [63:0] p);
      logic [129:0] t;
      t = ({66'd0, x} * {66'd0, y}) % {66'd0, p};
      return t[63:0];
   endfunction

   function automatic logic [63:0] mpow(input logic [63:0] base, input logic [63:0] e,
                                        input logic [63:0] p);
      logic [63:0] r;
      logic [63:0] bb;
      r  = 64'd1;
      bb = base % p;
      for (int i = 0; i < 64; i++) begin
         if (e[i]) r = mulmod(r, bb, p);
         bb = mulmod(bb, bb, p);
      end
      return r;
   endfunction

   function automatic logic [63:0] rhs_of(input logic [63:0] p, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] x);
      logic [129:0] t;
      t = {66'd0, mulmod(mulmod(x, x, p), x, p)} + {66'd0, mulmod(a, x, p)} + {66'd0, b % p};
      t = t % {66'd0, p};
      return t[63:0];
   endfunction

   function automatic bit rng_bad(input logic [63:0] p, input logic [63:0] a,
                                  input logic [63:0] b, input logic [63:0] x, input logic [63:0] y);
      return (p < 64'd3) || (p[0] == 1'b0) || (x >= p) || (y >= p) || (a >= p) || (b >= p);
   endfunction

   // Returns {range_err, on_curve}.
   function automatic logic [1:0] model(input logic [63:0] p, input logic [63:0] a,
                                        input logic [63:0] b, input logic [63:0] x,
                                        input logic [63:0] y, input bit inf);
      if (inf) return 2'b01;
      if (rng_bad(p, a, b, x, y)) return 2'b10;
      return {1'b0, mulmod(y, y, p) == rhs_of(p, a, b, x)};
   endfunction

   task automatic drive(input bit wide, input logic [63:0] p, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] x, input logic [63:0] y,
                        input bit inf, input bit g);
      if (wide) begin
         p64 = p; a64 = a; b64 = b; x64 = x; y64 = y; inf64 = inf; go64 = g;
      end else begin
         p8 = p[7:0]; a8 = a[7:0]; b8 = b[7:0]; x8 = x[7:0]; y8 = y[7:0]; inf8 = inf; go8 = g;
      end
   endtask

   function automatic logic [3:0] obs(input bit wide);
      return wide ? {busy64, done64, on64, err64} : {busy8, done8, on8, err8};
   endfunction

   // Latency k means done is first seen in the k-th cycle after the edge sampling go.
   task automatic run_pt(input bit wide, input logic [63:0] p_in, input logic [63:0] a_in,
                         input logic [63:0] b_in, input logic [63:0] x_in,
                         input logic [63:0] y_in, input bit inf, input string tag);
      logic [63:0] m, p, a, b, x, y;
      logic [1:0]  want;
      logic [3:0]  o;
      int          want_lat, lat;
      bit          seen, busy_ok;
      m = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
      p = p_in & m; a = a_in & m; b = b_in & m; x = x_in & m; y = y_in & m;
      want     = model(p, a, b, x, y, inf);
      want_lat = (inf || rng_bad(p, a, b, x, y)) ? 3 : 4 * (wide ? 64 : 8) + 14;
      @(negedge clk);
      drive(wide, p, a, b, x, y, inf, 1'b1);
      lat = 0; seen = 1'b0; busy_ok = 1'b1; o = 4'd0;
      while (!seen && lat < 400) begin
         @(negedge clk);
         lat++;
         if (lat == 2) drive(wide, ~p, ~a, ~b, {$urandom, $urandom}, {$urandom, $urandom}, ~inf, 1'b1);
         o = obs(wide);
         if (o[2]) seen = 1'b1;
         else if (!o[3]) busy_ok = 1'b0;
      end
      chk({tag, ".latency"}, 64'(lat), 64'(want_lat));
      chk({tag, ".busy_run"}, {63'd0, busy_ok}, 64'd1);
      chk({tag, ".busy_done"}, {63'd0, o[3]}, 64'd0);
      chk({tag, ".on_curve"}, {63'd0, o[1]}, {63'd0, want[0]});
      chk({tag, ".range_err"}, {63'd0, o[0]}, {63'd0, want[1]});
      repeat (3) @(negedge clk);
      o = obs(wide);
      chk({tag, ".hold"}, {61'd0, o[2:0]}, {61'd0, 1'b1, want[0], want[1]});
`ifdef ECC_PTCHK_NEG_EN
      begin
         logic [63:0] want_neg;
         want_neg = (inf || y == 64'd0) ? 64'd0 : ((p - y) & m);
         chk({tag, ".negPy"}, wide ? neg64 : {56'd0, neg8}, want_neg);
      end
`endif
      drive(wide, p, a, b, x, y, inf, 1'b0);
      @(negedge clk);
      chk({tag, ".idle"}, {60'd0, obs(wide)}, 64'd0);
   endtask

   initial begin
      logic [63:0] p, a, b, x, y, r, s;
      bit found;
      rst = 1'b0;
      drive(1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      drive(1'b1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      #12;
      chk("reset.dut8", {60'd0, obs(1'b0)}, 64'd0);
      chk("reset.dut64", {60'd0, obs(1'b1)}, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_pt(1'b0, 64'd17, 64'd2, 64'd2, 64'd5, 64'd1, 1'b0, "p17_5_1");
      run_pt(1'b0, 64'd17, 64'd2, 64'd2, 64'd6, 64'd3, 1'b0, "p17_6_3");
      run_pt(1'b0, 64'd17, 64'd2, 64'd2, 64'd5, 64'd2, 1'b0, "p17_5_2");
      run_pt(1'b0, 64'd17, 64'd2, 64'd2, 64'hFF, 64'hFF, 1'b1, "p17_inf");
      run_pt(1'b0, 64'd17, 64'd2, 64'd2, 64'd17, 64'd1, 1'b0, "p17_x_eq_p");
      run_pt(1'b0, 64'd17, 64'd2, 64'd2, 64'd3, 64'd0, 1'b0, "p17_y_zero");

      // Random odd or even moduli; half the points are forced onto the curve by search.
      for (int i = 0; i < 10; i++) begin
         p = 64'($urandom_range(3, 255));
         p[0] = (i % 4 != 3);
         a = 64'($urandom) % p; b = 64'($urandom) % p;
         x = (i % 5 == 4) ? p : 64'($urandom) % p;
         y = 64'($urandom) % p;
         if (i % 2 == 0) begin
            for (int k = 0; k < 256; k++) begin
               if (64'(k) < p && mulmod(64'(k), 64'(k), p) == rhs_of(p, a, b, x)) y = 64'(k);
            end
         end
         run_pt(1'b0, p, a, b, x, y, (i == 7), $sformatf("rand8_%0d", i));
      end

      // Asynchronous reset in the middle of MUL_AX.
      @(negedge clk);
      drive(1'b0, 64'd17, 64'd2, 64'd2, 64'd5, 64'd1, 1'b0, 1'b1);
      repeat (27) @(negedge clk);
      chk("rst_mul.busy_before", {63'd0, busy8}, 64'd1);
      #2 rst = 1'b0;
      #1 chk("rst_mul.async", {60'd0, obs(1'b0)}, 64'd0);
      go8 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_pt(1'b0, 64'd17, 64'd2, 64'd2, 64'd5, 64'd1, 1'b0, "after_rst");

      // Asynchronous reset while a valid result is being held.
      @(negedge clk);
      drive(1'b0, 64'd17, 64'd2, 64'd2, 64'd5, 64'd1, 1'b0, 1'b1);
      for (int k = 0; k < 100 && !done8; k++) @(negedge clk);
      chk("rst_done.on_before", {63'd0, on8}, 64'd1);
      #2 rst = 1'b0;
      #1 chk("rst_done.async", {60'd0, obs(1'b0)}, 64'd0);
      go8 = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Find a point on y^2 = x^3 + 7 mod 2^64-59 (p = 5 mod 8 square root).
      found = 1'b0; x = 64'd0; s = 64'd0;
      for (int k = 0; k < 64 && !found; k++) begin
         x = {$urandom, $urandom};
         if (x < PRIME64) begin
            r = rhs_of(PRIME64, 64'd0, 64'd7, x);
            s = mpow(r, (PRIME64 + 64'd3) >> 3, PRIME64);
            if (mulmod(s, s, PRIME64) != r)
               s = mulmod(s, mpow(64'd2, (PRIME64 - 64'd1) >> 2, PRIME64), PRIME64);
            if (mulmod(s, s, PRIME64) == r && s < PRIME64 - 64'd1) found = 1'b1;
         end
      end
      chk("p64.point_found", {63'd0, found}, 64'd1);
      run_pt(1'b1, PRIME64, 64'd0, 64'd7, x, s, 1'b0, "p64_valid");
      run_pt(1'b1, PRIME64, 64'd0, 64'd7, x, s + 64'd1, 1'b0, "p64_y_plus1");
      run_pt(1'b1, PRIME64, 64'd0, 64'd7, PRIME64, 64'd5, 1'b0, "p64_range");
      run_pt(1'b1, PRIME64, 64'd0, 64'd7, x, s, 1'b1, "p64_inf");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ecc_point_check.md
Name: ecc_point_check

Overview:
- Sequential affine point validator for short-Weierstrass curves y^2 = x^3 + A*x + B mod prime.
- It is the receiving end of scalar-multiply results and external public points: it accepts an (x, y, infinity) triple and decides whether the point lies on the curve before the point is used or released.
- Arithmetic uses one shared bit-serial modular multiplier, so area stays low.

Parameters:
- integer_size, 64, width of prime, curve coefficients and coordinates.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-low reset.
- go, in, 1, level request; sampled in IDLE.
- prime, in, integer_size, field modulus; must be odd and >= 3.
- A, in, integer_size, curve coefficient a.
- B, in, integer_size, curve coefficient b.
- Px, in, integer_size, point x.
- Py, in, integer_size, point y.
- infiniteP, in, 1, point is the point at infinity.
- busy, out, 1, high from LOAD through CMP.
- done, out, 1, result valid; held until go drops.
- on_curve, out, 1, point satisfies the curve equation (or is at infinity).
- range_err, out, 1, an input was out of range.

Behaviour:
- Reset (rst=0, async): state goes to IDLE; busy, done, on_curve and range_err are 0; the multiplier is aborted. Reset in any state, including mid-multiply, restarts cleanly.
- States: IDLE, LOAD, RANGE, MUL_XX, MUL_XXX, MUL_AX, MUL_YY, ADD_AX, ADD_B, CMP, DONE.
- IDLE: outputs are cleared. When go=1, go to LOAD.
- LOAD: register all inputs. Later input changes are ignored.
- RANGE:
  - If infiniteP=1: on_curve=1, range_err=0, go to DONE.
  - Else if prime<3, prime even, Px>=prime, Py>=prime, A>=prime or B>=prime: on_curve=0, range_err=1, go to DONE.
  - Otherwise go to MUL_XX.
- MUL states: each occupies exactly integer_size+2 cycles (1 start, integer_size iterations, 1 capture).
  - MUL_XX: t1 = x*x.
  - MUL_XXX: t1 = t1*x.
  - MUL_AX: t2 = A*x.
  - MUL_YY: t3 = y*y.
  - All products are mod prime.
- ADD_AX: t1 = (t1+t2) mod prime, using one conditional subtract on an integer_size+1-bit sum.
- ADD_B: t1 = (t1+B) mod prime, same method.
- CMP: on_curve = (t1==t3), range_err=0, go to DONE.
- DONE: done=1; on_curve and range_err are held. Return to IDLE when go=0. If go stays high, no restart occurs.
- Latency, counted from the IDLE edge that samples go=1 to the first cycle of done=1:
  - Normal path: 4*integer_size+14 cycles.
  - Infinity or range-error path: 3 cycles.
- busy=1 in LOAD through CMP; busy=0 in IDLE and DONE.
- The datapath is fully unsigned. All intermediates stay below prime after each step.

Optional Feature:
- Macro ECC_PTCHK_NEG_EN.
- When defined: adds output negPy (integer_size), registered on entry to DONE.
  - negPy = 0 if Py==0 or infiniteP=1.
  - Otherwise negPy = prime-Py.
  - Valid whenever done=1; reset value 0.
  - Used to build -P for subtraction in the ladder's consumers.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package ecc_pkg holds:
  - the state encoding localparams (4-bit);
  - the add-mod-p helper function (sum, conditional subtract);
  - the default integer_size.
- One sub-module: mod_mul_serial.
  - Ports: clk, rst, start, a, b, prime, product, done.
  - Interleaved MSB-first shift-add, acc = 2*acc + a_bit*b, with up to two conditional subtracts per iteration.
  - Accumulator is integer_size+2 bits.
  - done is a one-cycle pulse at iteration end.

Test Plan:
- integer_size=8, prime=17, A=2, B=2, P=(5,1), go held high -> done first high 46 cycles after sampling, on_curve=1, range_err=0; done stays high until go=0, then IDLE.
- Same curve, P=(6,3) -> on_curve=1. P=(5,2) -> on_curve=0, range_err=0.
- infiniteP=1 with Px=Py=0xFF -> done at cycle 3, on_curve=1, range_err=0. Px=17 -> done at cycle 3, on_curve=0, range_err=1.
- Pull rst low during MUL_AX -> busy, done and on_curve are 0 immediately (asynchronous). After release, a fresh request for (5,1) completes normally with on_curve=1.
- integer_size=64, secp-style prime 2^64-59, A=0, B=7, a known valid point and the same point with y+1 -> on_curve=1 then 0, latency 270 cycles each. With ECC_PTCHK_NEG_EN, for (5,1) p=17 -> negPy=16; for Py=0 -> negPy=0.
